// File: rtl/noise_sched_pkg.sv
// rtl/noise_sched_pkg.sv - shared constants, state encoding and write-beat type for the noise polynomial scheduler
package noise_sched_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;

    localparam int POLY_WORDS    = 512;
    localparam int NUM_POLYS_DEF = 3;
    localparam int LOCAL_AW      = 9;
    localparam int BANK_AW       = 11;
    localparam int IDX_W         = 2;
    localparam int DATA_W        = 16;
    localparam int WCNT_W        = 10;

    typedef struct packed {
        logic                we;
        logic [LOCAL_AW-1:0] addr;
        logic [DATA_W-1:0]   data;
    } wr_beat_t;

    // Bank address places each polynomial in its own POLY_WORDS-sized window.
    function automatic logic [BANK_AW-1:0] bank_addr(input logic [IDX_W-1:0] idx,
                                                     input logic [LOCAL_AW-1:0] local_addr);
        return {idx, local_addr};
    endfunction

endpackage

// File: rtl/noise_poly_scheduler_if.sv
// rtl/noise_poly_scheduler_if.sv - control, sampler and bank-write signals of the noise polynomial scheduler
interface noise_poly_scheduler_if;
    import noise_sched_pkg::*;

    logic                req;
    logic                fresh_seed;
    logic                busy;
    logic                batch_done;
    logic [IDX_W-1:0]    poly_idx;
    logic                err;
    logic                bs_start;
    logic                bs_reseed_needed;
    logic                bs_done;
    logic                bs_poly_wea;
    logic [LOCAL_AW-1:0] bs_poly_addra;
    logic [DATA_W-1:0]   bs_poly_dia;
    logic                mem_wea;
    logic [BANK_AW-1:0]  mem_addra;
    logic [DATA_W-1:0]   mem_dia;

    modport master (
        input  req, fresh_seed, bs_done, bs_poly_wea, bs_poly_addra, bs_poly_dia,
        output busy, batch_done, poly_idx, err, bs_start, bs_reseed_needed,
               mem_wea, mem_addra, mem_dia
    );

    modport slave (
        output req, fresh_seed, bs_done, bs_poly_wea, bs_poly_addra, bs_poly_dia,
        input  busy, batch_done, poly_idx, err, bs_start, bs_reseed_needed,
               mem_wea, mem_addra, mem_dia
    );

endinterface

// File: rtl/noise_wr_stage.sv
// rtl/noise_wr_stage.sv - registered sampler-to-bank write remap; optional write counter under NOISE_SCHED_WRCHECK_EN
module noise_wr_stage
    import noise_sched_pkg::*;
#(
    parameter int WORDS = POLY_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               accept,
    input  logic               launch,
    input  logic               check,
    input  logic [IDX_W-1:0]   poly_idx,
    input  wr_beat_t           beat,
    output logic               mem_wea,
    output logic [BANK_AW-1:0] mem_addra,
    output logic [DATA_W-1:0]  mem_dia,
    output logic               err
);

    logic               wea_q, wea_d;
    logic [BANK_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  dia_q, dia_d;

    // Address/data hold their last value between writes to avoid needless bank-bus toggling.
    always_comb begin
        wea_d  = beat.we & accept;
        addr_d = addr_q;
        dia_d  = dia_q;
        if (beat.we && accept) begin
            addr_d = bank_addr(poly_idx, beat.addr);
            dia_d  = beat.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wea_q  <= 1'b0;
            addr_q <= '0;
            dia_q  <= '0;
        end else begin
            wea_q  <= wea_d;
            addr_q <= addr_d;
            dia_q  <= dia_d;
        end
    end

    assign mem_wea   = wea_q;
    assign mem_addra = addr_q;
    assign mem_dia   = dia_q;

`ifdef NOISE_SCHED_WRCHECK_EN
    logic [WCNT_W-1:0] cnt_q, cnt_d, cnt_now;
    logic              err_q, err_d;

    // The final write coincides with the completion pulse, so it is included in the compare.
    always_comb begin
        cnt_now = cnt_q + {{(WCNT_W-1){1'b0}}, wea_d};
        cnt_d   = launch ? '0 : cnt_now;
        err_d   = err_q | (check && (cnt_now != WCNT_W'(WORDS)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = launch ^ check ^ (WORDS != 0);
    assign err        = 1'b0;
`endif

endmodule

// File: rtl/noise_poly_scheduler.sv
// rtl/noise_poly_scheduler.sv - sequences binomial-sampler runs over a batch of polynomials; NOISE_SCHED_WRCHECK_EN adds write-count checking
module noise_poly_scheduler
    import noise_sched_pkg::*;
#(
    parameter int NUM_POLYS  = NUM_POLYS_DEF,
    parameter int POLY_WORDS = noise_sched_pkg::POLY_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noise_poly_scheduler_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POLYS - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fresh_q, fresh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic             reseed_q, reseed_d;

    // Launch outputs are computed one state ahead so bs_start is a flop that is high during LAUNCH.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fresh_d  = fresh_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        start_d  = 1'b0;
        reseed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    fresh_d  = bus.fresh_seed;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    start_d  = 1'b1;
                    reseed_d = bus.fresh_seed;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (bus.bs_done) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                start_d  = 1'b1;
                reseed_d = fresh_q && (idx_q == '0);
                state_d  = ST_LAUNCH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            fresh_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            reseed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fresh_q  <= fresh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            start_q  <= start_d;
            reseed_q <= reseed_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.batch_done       = done_q;
    assign bus.poly_idx         = idx_q;
    assign bus.bs_start         = start_q;
    assign bus.bs_reseed_needed = reseed_q;

    wr_beat_t beat;
    assign beat = {bus.bs_poly_wea, bus.bs_poly_addra, bus.bs_poly_dia};

    // idx_q is still the pre-increment value on the bs_done cycle, so the last write lands in the right window.
    noise_wr_stage #(
        .WORDS (POLY_WORDS)
    ) u_wr_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (state_q != ST_IDLE),
        .launch    (state_q == ST_LAUNCH),
        .check     ((state_q == ST_WAIT_DONE) && bus.bs_done),
        .poly_idx  (idx_q),
        .beat      (beat),
        .mem_wea   (bus.mem_wea),
        .mem_addra (bus.mem_addra),
        .mem_dia   (bus.mem_dia),
        .err       (bus.err)
    );

endmodule

// File: tb/tb_noise_poly_scheduler.sv
// tb/tb_noise_poly_scheduler.sv - directed self-checking bench for noise_poly_scheduler
module tb_noise_poly_scheduler;

`ifdef NOISE_SCHED_WRCHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic clk;
    logic rst_n;

    noise_poly_scheduler_if bus ();

    noise_poly_scheduler #(
        .NUM_POLYS  (3),
        .POLY_WORDS (512)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    bit seen [0:2047];
    int start_cnt, reseed_cnt, first_reseed, done_cnt, wr_cnt, dup_cnt, data_err, oob_cnt;
    int bsdone_n, first_addr, bd_cyc, last_wr_cyc, cur_poly;
    int start_cyc [3];
    int start_poly [3];
    int done_cyc [3];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bs_start) begin
                if (start_cnt < 3) begin
                    start_cyc[start_cnt]  = cyc;
                    start_poly[start_cnt] = int'(bus.poly_idx);
                end
                if (bus.bs_reseed_needed) begin
                    reseed_cnt++;
                    if (start_cnt == 0) first_reseed = 1;
                end
                start_cnt++;
            end
            if (bus.bs_done && bsdone_n < 3) begin
                done_cyc[bsdone_n] = cyc;
                bsdone_n++;
            end
            if (bus.batch_done) begin
                done_cnt++;
                bd_cyc = cyc;
            end
            if (bus.mem_wea) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (first_addr < 0) first_addr = int'(bus.mem_addra);
                if (bus.mem_addra >= 11'd1536) oob_cnt++;
                if (seen[bus.mem_addra]) dup_cnt++;
                seen[bus.mem_addra] = 1'b1;
                if (bus.mem_dia !== (16'h3C00 ^ {5'b0, bus.mem_addra})) data_err++;
            end
        end
    end

    task automatic clear_sb();
        for (int a = 0; a < 2048; a++) seen[a] = 1'b0;
        start_cnt = 0; reseed_cnt = 0; first_reseed = 0; done_cnt = 0; wr_cnt = 0;
        dup_cnt = 0; data_err = 0; oob_cnt = 0; bsdone_n = 0; first_addr = -1;
        bd_cyc = 0; last_wr_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            start_cyc[k] = -100; start_poly[k] = -1; done_cyc[k] = 0;
        end
    endtask

    function automatic int coverage();
        int n = 0;
        for (int a = 0; a < 1536; a++) n += int'(seen[a]);
        return n;
    endfunction

    task automatic pulse_req(input bit fresh);
        bus.req = 1'b1;
        bus.fresh_seed = fresh;
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.fresh_seed = 1'b0;
    endtask

    // Model sampler: waits for bs_start, then streams nw writes with bs_done on the last one.
    task automatic do_poly(input int nw, input bit give_done, input int req_at);
        bit got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.bs_start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("bs_start_seen", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            bus.bs_poly_wea   = 1'b1;
            bus.bs_poly_addra = 9'(i);
            bus.bs_poly_dia   = 16'h3C00 ^ 16'(cur_poly * 512 + i);
            bus.bs_done       = give_done && (i == nw - 1);
            bus.req           = (i == req_at);
        end
        @(posedge clk); #1;
        bus.bs_poly_wea = 1'b0;
        bus.bs_done     = 1'b0;
        bus.req         = 1'b0;
    endtask

    task automatic run_batch(input bit fresh, input int n0, input int n1, input int n2, input int req_at);
        int nw [3];
        nw[0] = n0; nw[1] = n1; nw[2] = n2;
        clear_sb();
        pulse_req(fresh);
        for (int p = 0; p < 3; p++) begin
            cur_poly = p;
            do_poly(nw[p], 1'b1, (p == 0) ? req_at : -1);
        end
        for (int k = 0; k < 10 && done_cnt == 0; k++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = 1'b0; bus.fresh_seed = 1'b0; bus.bs_done = 1'b0;
        bus.bs_poly_wea = 1'b0; bus.bs_poly_addra = '0; bus.bs_poly_dia = '0;
        cur_poly = 0;
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_batch_done", 32'(bus.batch_done), 32'd0);
        check("rst_poly_idx",   32'(bus.poly_idx),   32'd0);
        check("rst_bs_start",   32'(bus.bs_start),   32'd0);
        check("rst_mem_wea",    32'(bus.mem_wea),    32'd0);
        check("rst_mem_addra",  32'(bus.mem_addra),  32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fresh-seed batch, full polynomials
        run_batch(1'b1, 512, 512, 512, -1);
        check("b1_starts",      32'(start_cnt),  32'd3);
        check("b1_reseeds",     32'(reseed_cnt), 32'd1);
        check("b1_first_rsd",   32'(first_reseed), 32'd1);
        check("b1_coverage",    32'(coverage()), 32'd1536);
        check("b1_writes",      32'(wr_cnt),     32'd1536);
        check("b1_dups",        32'(dup_cnt),    32'd0);
        check("b1_oob",         32'(oob_cnt),    32'd0);
        check("b1_data",        32'(data_err),   32'd0);
        check("b1_batch_done",  32'(done_cnt),   32'd1);
        check("b1_done_to_start", 32'(start_cyc[1] - done_cyc[0]), 32'd2);
        check("b1_start1_idx",  32'(start_poly[1]), 32'd1);
        check("b1_start2_idx",  32'(start_poly[2]), 32'd2);
        check("b1_done_lat",    32'(bd_cyc - done_cyc[2]), 32'd1);
        check("b1_last_wr_cyc", 32'(last_wr_cyc), 32'(bd_cyc));
        check("b1_busy_after",  32'(bus.busy),   32'd0);
        check("b1_err",         32'(bus.err),    32'd0);

        // No reseed, with a stray req while busy
        run_batch(1'b0, 512, 512, 512, 10);
        repeat (5) @(posedge clk);
        #1;
        check("b2_reseeds",     32'(reseed_cnt), 32'd0);
        check("b2_starts",      32'(start_cnt),  32'd3);
        check("b2_batch_done",  32'(done_cnt),   32'd1);
        check("b2_coverage",    32'(coverage()), 32'd1536);

        // Writes and bs_done while idle are dropped
        bus.bs_poly_wea = 1'b1; bus.bs_poly_addra = 9'd5; bus.bs_done = 1'b1;
        @(posedge clk); #1;
        bus.bs_poly_wea = 1'b0; bus.bs_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_wr_drop",   32'(wr_cnt),     32'd1536);
        check("idle_done_ign",  32'(done_cnt),   32'd1);
        check("idle_busy",      32'(bus.busy),   32'd0);
        check("idle_no_start",  32'(start_cnt),  32'd3);

        // Reset in the middle of polynomial 1
        clear_sb();
        pulse_req(1'b1);
        cur_poly = 0;
        do_poly(512, 1'b1, -1);
        cur_poly = 1;
        do_poly(100, 1'b0, -1);
        check("pre_rst_wea",    32'(bus.mem_wea),  32'd1);
        check("pre_rst_idx",    32'(bus.poly_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      32'(bus.busy),       32'd0);
        check("arst_poly_idx",  32'(bus.poly_idx),   32'd0);
        check("arst_mem_wea",   32'(bus.mem_wea),    32'd0);
        check("arst_mem_addra", 32'(bus.mem_addra),  32'd0);
        check("arst_mem_dia",   32'(bus.mem_dia),    32'd0);
        check("arst_bs_start",  32'(bus.bs_start),   32'd0);
        check("arst_reseed",    32'(bus.bs_reseed_needed), 32'd0);
        check("arst_batch_done",32'(bus.batch_done), 32'd0);
        check("arst_err",       32'(bus.err),        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done",  32'(done_cnt),   32'd0);
        run_batch(1'b1, 512, 512, 512, -1);
        check("b3_first_idx",   32'(start_poly[0]), 32'd0);
        check("b3_first_addr",  32'(first_addr), 32'd0);
        check("b3_batch_done",  32'(done_cnt),   32'd1);
        check("b3_coverage",    32'(coverage()), 32'd1536);
        check("b3_reseeds",     32'(reseed_cnt), 32'd1);

        // Short polynomial sets the sticky write-count error when checking is built in
        run_batch(1'b0, 511, 512, 512, -1);
        check("b4_batch_done",  32'(done_cnt),   32'd1);
        check("b4_err",         32'(bus.err),    EXP_ERR);
        run_batch(1'b0, 512, 512, 512, -1);
        check("b5_batch_done",  32'(done_cnt),   32'd1);
        check("b5_err_sticky",  32'(bus.err),    EXP_ERR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
